// File: rtl/layer_sequencer.sv
// Per-image layer scheduler: releases one layer at a time, owns the feature-RAM
// ping-pong bank select, queues one start request and guards each layer with a watchdog.
module layer_sequencer #(
  parameter int unsigned N_LAYERS  = 4,
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned TIMEOUT   = 50000,
  localparam int unsigned LW       = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_LAYERS-1:0] layer_done,
  output logic [N_LAYERS-1:0] layer_hold,
  output logic                wr_bank,
  output logic [LW-1:0]       cur_layer,
  output logic                busy,
  output logic                img_done,
  output logic [15:0]         img_cnt,
  output logic [1:0]          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_FIN,
    S_ERR
  } state_t;

  localparam logic [LW-1:0]        LAST_LAYER = LW'(N_LAYERS - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LIMIT   = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [N_LAYERS-1:0]  ALL_HOLD   = {N_LAYERS{1'b1}};

  state_t               state;
  logic                 pending;
  logic [TIMEOUT_W-1:0] watchdog;
  logic                 done_cur_c;
  logic [LW-1:0]        nxt_layer_c;
  logic                 in_flight_c;

  assign done_cur_c  = layer_done[cur_layer];
  assign nxt_layer_c = LW'(cur_layer + 1'b1);
  assign in_flight_c = (state == S_RUN) || (state == S_GAP) || (state == S_FIN);

  // Sequencer state and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      layer_hold <= ALL_HOLD;
      wr_bank    <= 1'b0;
      cur_layer  <= '0;
      busy       <= 1'b0;
      img_done   <= 1'b0;
      img_cnt    <= 16'd0;
      err        <= 2'b00;
      pending    <= 1'b0;
      watchdog   <= '0;
    end else begin
      img_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start || pending) begin
            state      <= S_RUN;
            cur_layer  <= '0;
            wr_bank    <= 1'b0;
            busy       <= 1'b1;
            layer_hold <= ~N_LAYERS'(1);
            pending    <= 1'b0;
            watchdog   <= '0;
          end
        end
        S_RUN: begin
          // A done in the timeout cycle still counts as a clean finish
          if (done_cur_c) begin
            layer_hold <= ALL_HOLD;
            watchdog   <= '0;
            if (cur_layer == LAST_LAYER) begin
              state    <= S_FIN;
              img_done <= 1'b1;
              img_cnt  <= img_cnt + 16'd1;
            end else begin
              state <= S_GAP;
            end
          end else if (watchdog == WD_LIMIT) begin
            state      <= S_ERR;
            layer_hold <= ALL_HOLD;
            err[0]     <= 1'b1;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        S_GAP: begin
          state      <= S_RUN;
          cur_layer  <= nxt_layer_c;
          wr_bank    <= ~wr_bank;
          layer_hold <= ~(N_LAYERS'(1) << nxt_layer_c);
        end
        S_FIN: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cur_layer <= '0;
        end
        S_ERR: begin
          layer_hold <= ALL_HOLD;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // One request may queue behind the running image; a second one overruns
      if (start && in_flight_c) begin
        if (pending) begin
          err[1] <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: a behavioural image/layer model predicts
// every output each cycle; the bench also plays the role of the layers.
module tb_layer_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned TW = 16;
  localparam int unsigned TO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  layer_done;
  logic [N-1:0]  layer_hold;
  logic          wr_bank;
  logic [1:0]    cur_layer;
  logic          busy;
  logic          img_done;
  logic [15:0]   img_cnt;
  logic [1:0]    err;

  always #5 clk = ~clk;

  layer_sequencer #(
    .N_LAYERS (N),
    .TIMEOUT_W(TW),
    .TIMEOUT  (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .layer_done(layer_done),
    .layer_hold(layer_hold),
    .wr_bank   (wr_bank),
    .cur_layer (cur_layer),
    .busy      (busy),
    .img_done  (img_done),
    .img_cnt   (img_cnt),
    .err       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 25)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: an image is either idle, running layer m_layer, in the
  // turnaround gap, finishing, or stuck after a timeout.
  bit m_run, m_gap, m_fin, m_stuck, m_pend, m_err1, m_bank;
  int m_layer, m_age, m_cnt;

  // Layer behaviour knobs (per-mille probabilities)
  int unsigned p_start, p_done, p_spur;
  int fixed_lat, kill;

  function automatic void model_reset();
    m_run = 0; m_gap = 0; m_fin = 0; m_stuck = 0;
    m_pend = 0; m_err1 = 0; m_bank = 0;
    m_layer = 0; m_age = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(input bit r, input bit st, input logic [N-1:0] dn);
    bit idle;
    if (r) begin
      model_reset();
      return;
    end
    idle = !(m_run || m_gap || m_fin || m_stuck);
    if (m_stuck) return;
    if (idle) begin
      if (st || m_pend) begin
        m_run = 1; m_layer = 0; m_age = 0; m_pend = 0; m_bank = 0;
      end
      return;
    end
    if (st) begin
      if (m_pend) m_err1 = 1;
      else m_pend = 1;
    end
    if (m_fin) begin
      m_fin = 0; m_layer = 0;
    end else if (m_gap) begin
      m_gap = 0; m_run = 1; m_layer++; m_age = 0; m_bank = !m_bank;
    end else if (dn[m_layer]) begin
      m_run = 0;
      if (m_layer == N - 1) begin
        m_fin = 1; m_cnt = (m_cnt + 1) % 65536;
      end else begin
        m_gap = 1;
      end
    end else if (m_age == int'(TO) - 1) begin
      m_run = 0; m_stuck = 1;
    end else begin
      m_age++;
    end
  endfunction

  task automatic compare_all();
    logic [N-1:0] exp_hold;
    exp_hold = m_run ? ~(N'(1) << m_layer) : {N{1'b1}};
    check("layer_hold", 32'(layer_hold), 32'(exp_hold));
    check("wr_bank",    32'(wr_bank),    32'(m_bank));
    check("cur_layer",  32'(cur_layer),  32'(m_layer));
    check("busy",       32'(busy),       32'(m_run || m_gap || m_fin || m_stuck));
    check("img_done",   32'(img_done),   32'(m_fin));
    check("img_cnt",    32'(img_cnt),    32'(m_cnt));
    check("err",        32'(err),        32'({m_err1, m_stuck}));
  endtask

  // One clock: drive at negedge, step the model at the edge, compare after it
  task automatic drive(input bit r, input bit fs);
    logic [N-1:0] dn;
    bit st;
    @(negedge clk);
    st = fs || ($urandom_range(999) < p_start);
    for (int i = 0; i < int'(N); i++) dn[i] = ($urandom_range(999) < p_spur);
    if (m_run) begin
      if (fixed_lat > 0) dn[m_layer] = (m_age == fixed_lat - 1);
      else dn[m_layer] = ($urandom_range(999) < p_done);
      if (m_layer == kill) dn[m_layer] = 1'b0;
    end
    rst = r; start = st; layer_done = dn;
    @(posedge clk);
    model_step(r, st, dn);
    #1;
    compare_all();
  endtask

  task automatic knobs(input int unsigned ps, input int unsigned pd, input int unsigned pp,
                       input int fl, input int kl);
    p_start = ps; p_done = pd; p_spur = pp; fixed_lat = fl; kill = kl;
  endtask

  initial begin
    bit reached;
    rst = 1'b1; start = 1'b0; layer_done = '0;
    model_reset();
    knobs(0, 0, 0, 20, -1);
    repeat (3) drive(1, 0);

    // Single image, every layer answers 20 cycles after release
    drive(0, 1);
    repeat (120) drive(0, 0);
    check("img1_cnt", 32'(img_cnt), 32'd1);

    // Queued start during layer 1 runs a second image back to back
    drive(0, 1);
    repeat (30) drive(0, 0);
    drive(0, 1);
    repeat (200) drive(0, 0);
    check("queued_cnt", 32'(img_cnt), 32'd3);
    check("queued_err", 32'(err), 32'd0);

    // Three starts in one image: two images, overrun flagged
    drive(0, 1);
    repeat (10) drive(0, 0);
    drive(0, 1);
    repeat (10) drive(0, 0);
    drive(0, 1);
    repeat (250) drive(0, 0);
    check("overrun_cnt", 32'(img_cnt), 32'd5);
    check("overrun_err", 32'(err), 32'd2);

    // Done arriving exactly in the timeout cycle wins
    drive(1, 0);
    knobs(0, 0, 30, int'(TO), -1);
    drive(0, 1);
    repeat (420) drive(0, 0);
    check("tie_cnt", 32'(img_cnt), 32'd1);
    check("tie_err", 32'(err), 32'd0);

    // Reset while layer 2 runs, then a clean restart
    knobs(0, 0, 40, 15, -1);
    drive(0, 1);
    reached = 0;
    for (int i = 0; i < 300 && !reached; i++) begin
      drive(0, 0);
      reached = m_run && (m_layer == 2);
    end
    check("reach_layer2", 32'(reached), 32'd1);
    drive(1, 0);
    check("midrst_hold", 32'(layer_hold), 32'hF);
    drive(0, 1);
    check("restart_layer", 32'(cur_layer), 32'd0);
    repeat (100) drive(0, 0);

    // Layer 2 never answers: watchdog error, later starts ignored
    drive(1, 0);
    knobs(0, 0, 40, 10, 2);
    drive(0, 1);
    repeat (150) drive(0, 0);
    knobs(50, 0, 40, 10, 2);
    repeat (60) drive(0, 0);
    check("to_err", 32'(err), 32'd1);
    check("to_busy", 32'(busy), 32'd1);
    check("to_hold", 32'(layer_hold), 32'hF);
    knobs(0, 0, 0, 10, -1);
    drive(1, 0);
    check("to_rst_err", 32'(err), 32'd0);

    // Random traffic: fast layers, then slow layers that may time out
    knobs(25, 90, 40, 0, -1);
    repeat (3000) drive(0, 0);
    for (int k = 0; k < 6; k++) begin
      drive(1, 0);
      knobs(20, 12, 30, 0, -1);
      repeat (300) drive(0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
